// File: rtl/fetch_unit_if.sv
// Signal bundle between the prefetch stage, program memory and the core.
// The master side is the fetch unit; the slave side is memory plus core.
interface fetch_unit_if #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12
);
   // program memory read port
   logic                mem_req;
   logic [ADDRSIZE-1:0] mem_addr;
   logic                mem_ack;
   logic [WIDTH-1:0]    mem_rdata;

   // branch redirect from the core
   logic                redirect;
   logic [ADDRSIZE-1:0] redirect_pc;

   // instruction handoff to the core
   logic                ir_valid;
   logic                ir_ready;
   logic [WIDTH-1:0]    ir_data;
   logic [ADDRSIZE-1:0] ir_pc;
   logic                halted;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      input  redirect, redirect_pc,
      output ir_valid, ir_data, ir_pc, halted,
      input  ir_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      output redirect, redirect_pc,
      input  ir_valid, ir_data, ir_pc, halted,
      output ir_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetch stage: reads words from program memory with a single
// outstanding req/ack transfer, buffers {word, pc} in a small FIFO and hands
// the head to the core over valid/ready. Redirect flushes and refetches;
// enqueuing an HLT word stops prefetching until the next redirect or reset.
module fetch_unit #(
   parameter int         WIDTH    = 32,
   parameter int         ADDRSIZE = 12,
   parameter int         DEPTH    = 4,
   parameter logic [3:0] HLT_OP   = 4'b1011
) (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HALTED  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDRSIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
   logic                ir_valid_q, ir_valid_d;
   logic                halted_q, halted_d;

   // FIFO storage: small enough to live in flops, which lets the head be
   // read combinationally so the core sees no bubble after a dequeue.
   logic [WIDTH-1:0]    data_q [DEPTH];
   logic [ADDRSIZE-1:0] pc_q   [DEPTH];
   logic [DEPTH-1:0]    wr_en;

   logic ack_ok;        // ack belongs to our outstanding request
   logic still_pending; // request remains outstanding after this edge
   logic deq;
   logic enq;
   logic is_hlt;

   assign ack_ok        = mem_req_q & bus.mem_ack;
   assign still_pending = mem_req_q & ~bus.mem_ack;
   assign deq           = ir_valid_q & bus.ir_ready;
   // Acked data is kept only in FETCH and only when no redirect kills it.
   assign enq           = ack_ok & (state_q == FETCH) & ~bus.redirect;
   assign is_hlt        = (bus.mem_rdata[WIDTH-1 -: 4] == HLT_OP);

   // Per-entry write strobes.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = enq & (wr_ptr_q == PTRW'(gi));
   end

   // Next-state computation for pointers, count, fetch address and FSM.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      halted_d   = halted_q;

      if (deq) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end

      if (bus.redirect) begin
         // A head consumed this cycle is already gone; everything else is
         // stale, so the FIFO simply restarts empty.
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = bus.redirect_pc;
         halted_d   = 1'b0;
         state_d    = still_pending ? DISCARD : FETCH;
      end else begin
         count_d = count_q + {{(CNTW-1){1'b0}}, enq} - {{(CNTW-1){1'b0}}, deq};
         if (enq) begin
            wr_ptr_d   = wr_ptr_q + PTRW'(1);
            fetch_pc_d = mem_addr_q + ADDRSIZE'(1);
            if (is_hlt) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end
         end
         if ((state_q == DISCARD) && ack_ok) begin
            state_d = FETCH;
         end
      end

      // Request issue: hold an outstanding request until its ack; otherwise
      // fetch whenever there is guaranteed room for the returning word.
      if (still_pending) begin
         mem_req_d  = mem_req_q;
         mem_addr_d = mem_addr_q;
      end else if ((state_d == FETCH) && (count_d < DEPTH_C)) begin
         mem_req_d  = 1'b1;
         mem_addr_d = fetch_pc_d;
      end else begin
         mem_req_d  = 1'b0;
      end

      ir_valid_d = (count_d != '0);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         fetch_pc_q <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   // FIFO entry storage; cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end else if (wr_en[i]) begin
            data_q[i] <= bus.mem_rdata;
            pc_q[i]   <= mem_addr_q;
         end
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.ir_data  = data_q[rd_ptr_q];
   assign bus.ir_pc    = pc_q[rd_ptr_q];
   assign bus.halted   = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run, all
// checked cycle by cycle against a queue-based reference of the prefetcher.
module tb_fetch_unit;
   localparam int         WIDTH = 32;
   localparam int         AW    = 12;
   localparam int         DEPTH = 4;
   localparam logic [3:0] HLT   = 4'b1011;

   typedef struct packed {
      logic [AW-1:0]    pc;
      logic [WIDTH-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic reset;

   fetch_unit_if #(.WIDTH(WIDTH), .ADDRSIZE(AW)) bus_if ();

   fetch_unit #(.WIDTH(WIDTH), .ADDRSIZE(AW), .DEPTH(DEPTH), .HLT_OP(HLT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial forever #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] mem [4096];

   // memory responder controls
   int   fixed_lat = 1;   // 0 = random 1..3
   logic resp_en   = 1'b1;
   logic force_ack = 1'b0;

   // reference model state (describes the DUT after the coming edge)
   ent_t          q[$];
   logic [AW-1:0] fetch_m, addr_m;
   logic          req_m, halted_m, stale_m, new_req_m;
   logic          obs_en = 1'b0;

   // observation logs
   ent_t          hs_log[$];
   logic [AW-1:0] req_log[$];
   logic          prev_req = 1'b0, prev_ack = 1'b0;
   logic          last_hs, last_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      total++;
      bad++;
      $error("FAIL %s: observed=timeout expected=event", tag);
   endtask

   function automatic void model_reset();
      q.delete();
      fetch_m  = '0;
      addr_m   = '0;
      req_m    = 1'b0;
      halted_m = 1'b0;
      stale_m  = 1'b0;
   endfunction

   function automatic logic [WIDTH-1:0] rand_word(input bit allow_hlt);
      logic [WIDTH-1:0] w;
      w = $urandom;
      if (w[31:28] == HLT) w[28] = ~w[28];
      if (allow_hlt && ($urandom_range(0, 15) == 0)) w[31:28] = HLT;
      return w;
   endfunction

   // Compare DUT outputs with the model, then advance the model across the
   // coming clock edge using the inputs currently driven.
   task automatic observe();
      logic hs, ack;
      if (obs_en) begin
         chk("mem_req", {63'd0, bus_if.mem_req}, {63'd0, req_m});
         if (req_m) chk("mem_addr", {52'd0, bus_if.mem_addr}, {52'd0, addr_m});
         chk("ir_valid", {63'd0, bus_if.ir_valid}, {63'd0, (q.size() != 0)});
         if (q.size() != 0) begin
            chk("ir_pc", {52'd0, bus_if.ir_pc}, {52'd0, q[0].pc});
            chk("ir_data", {32'd0, bus_if.ir_data}, {32'd0, q[0].data});
         end
         chk("halted", {63'd0, bus_if.halted}, {63'd0, halted_m});
      end
      if (bus_if.mem_req === 1'b1 && (!prev_req || prev_ack)) req_log.push_back(bus_if.mem_addr);
      prev_req  = (bus_if.mem_req === 1'b1);
      prev_ack  = (bus_if.mem_req === 1'b1) && bus_if.mem_ack;
      hs        = (q.size() != 0) && bus_if.ir_ready;
      ack       = req_m && bus_if.mem_ack;
      last_hs   = hs;
      last_ack  = ack;
      new_req_m = 1'b0;
      if (reset) begin
         model_reset();
      end else begin
         if (hs) begin
            $display("deq pc=%03h data=%08h", q[0].pc, q[0].data);
            hs_log.push_back(q[0]);
            void'(q.pop_front());
         end
         if (bus_if.redirect) begin
            q.delete();
            fetch_m  = bus_if.redirect_pc;
            halted_m = 1'b0;
            stale_m  = req_m && !ack;
         end else if (ack) begin
            if (stale_m) begin
               stale_m = 1'b0;
            end else begin
               q.push_back('{pc: addr_m, data: bus_if.mem_rdata});
               fetch_m = addr_m + 12'd1;
               if (bus_if.mem_rdata[31:28] == HLT) halted_m = 1'b1;
            end
         end
         if (!(req_m && !ack)) begin
            if (!halted_m && q.size() < DEPTH) begin
               req_m     = 1'b1;
               addr_m    = fetch_m;
               new_req_m = 1'b1;
            end else begin
               req_m = 1'b0;
            end
         end
      end
   endtask

   task automatic tick(input logic rst, input logic rdy, input logic redir, input logic [AW-1:0] rpc);
      @(negedge clk);
      reset              = rst;
      bus_if.ir_ready    = rdy;
      bus_if.redirect    = redir;
      bus_if.redirect_pc = rpc;
      #1;
      observe();
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, 1'b0, '0);
      hs_log.delete();
      req_log.delete();
   endtask

   // Program memory model with 1..N cycle latency, or manual ack control.
   initial begin : responder
      int wait_cnt;
      int cur_lat;
      wait_cnt = 0;
      cur_lat  = 1;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            bus_if.mem_ack   = force_ack;
            bus_if.mem_rdata = mem[bus_if.mem_addr];
            wait_cnt = 0;
         end else begin
            if (bus_if.mem_ack || bus_if.mem_req !== 1'b1) begin
               wait_cnt = 0;
               cur_lat  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            end
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = $urandom;
            if (bus_if.mem_req === 1'b1) begin
               wait_cnt++;
               if (wait_cnt >= cur_lat) begin
                  bus_if.mem_ack   = 1'b1;
                  bus_if.mem_rdata = mem[bus_if.mem_addr];
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      bit found;
      reset = 1'b1;
      bus_if.ir_ready = 1'b0;
      bus_if.redirect = 1'b0;
      bus_if.redirect_pc = '0;
      for (int i = 0; i < 4096; i++) mem[i] = rand_word(1'b0);
      model_reset();
      do_reset();
      obs_en = 1'b1;

      // reset state
      chk("rst_mem_req", {63'd0, bus_if.mem_req}, 64'd0);
      chk("rst_mem_addr", {52'd0, bus_if.mem_addr}, 64'd0);
      chk("rst_ir_valid", {63'd0, bus_if.ir_valid}, 64'd0);
      chk("rst_ir_data", {32'd0, bus_if.ir_data}, 64'd0);
      chk("rst_ir_pc", {52'd0, bus_if.ir_pc}, 64'd0);
      chk("rst_halted", {63'd0, bus_if.halted}, 64'd0);

      // ADD, ADD, HLT with 1-cycle memory and a ready core
      mem[0] = 32'h1000_0001; mem[1] = 32'h1000_0002;
      mem[2] = 32'hB000_0000; mem[3] = 32'h1000_0003;
      fixed_lat = 1;
      repeat (12) tick(1'b0, 1'b1, 1'b0, '0);
      chk("t1_nreq", req_log.size(), 64'd3);
      chk("t1_ndeq", hs_log.size(), 64'd3);
      if (req_log.size() == 3) chk("t1_req2", {52'd0, req_log[2]}, 64'd2);
      if (hs_log.size() == 3) chk("t1_pc2", {52'd0, hs_log[2].pc}, 64'd2);
      chk("t1_halted", {63'd0, bus_if.halted}, 64'd1);
      chk("t1_req_idle", {63'd0, bus_if.mem_req}, 64'd0);

      // stalled core: FIFO fills with exactly DEPTH words
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = rand_word(1'b0);
      repeat (12) tick(1'b0, 1'b0, 1'b0, '0);
      chk("t2_nreq", req_log.size(), 64'd4);
      chk("t2_req_low", {63'd0, bus_if.mem_req}, 64'd0);
      chk("t2_head_pc", {52'd0, bus_if.ir_pc}, 64'd0);
      tick(1'b0, 1'b1, 1'b0, '0);
      tick(1'b0, 1'b0, 1'b0, '0);
      chk("t2_refill_req", {63'd0, bus_if.mem_req}, 64'd1);
      chk("t2_refill_addr", {52'd0, bus_if.mem_addr}, 64'd4);

      // redirect during a 3-cycle pending request to address 5
      do_reset();
      fixed_lat = 3;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         tick(1'b0, 1'b1, 1'b0, '0);
         if (new_req_m && addr_m == 12'd5) found = 1'b1;
      end
      if (!found) timeout_fail("t3_wait_req5");
      tick(1'b0, 1'b1, 1'b1, 12'h100);
      chk("t3_ack_at_redirect", {63'd0, last_ack}, 64'd0);
      hs_log.delete();
      req_log.delete();
      tick(1'b0, 1'b1, 1'b0, '0);
      chk("t3_addr_held", {52'd0, bus_if.mem_addr}, 64'd5);
      repeat (20) tick(1'b0, 1'b1, 1'b0, '0);
      chk("t3_has_req", {63'd0, (req_log.size() != 0)}, 64'd1);
      if (req_log.size() != 0) chk("t3_first_req", {52'd0, req_log[0]}, 64'h100);
      chk("t3_has_deq", {63'd0, (hs_log.size() != 0)}, 64'd1);
      if (hs_log.size() != 0) chk("t3_first_pc", {52'd0, hs_log[0].pc}, 64'h100);

      // redirect coinciding with mem_ack and a handshake
      do_reset();
      fixed_lat = 1;
      repeat (5) tick(1'b0, 1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 1'b1, 12'h200);
      chk("t4_hs_at_redirect", {63'd0, last_hs}, 64'd1);
      chk("t4_ack_at_redirect", {63'd0, last_ack}, 64'd1);
      tick(1'b0, 1'b1, 1'b0, '0);
      chk("t4_valid_low", {63'd0, bus_if.ir_valid}, 64'd0);
      chk("t4_req", {63'd0, bus_if.mem_req}, 64'd1);
      chk("t4_addr", {52'd0, bus_if.mem_addr}, 64'h200);

      // address wrap from 0xFFF to 0x000
      do_reset();
      mem[12'hFFF] = 32'h0000_0000;
      tick(1'b0, 1'b1, 1'b1, 12'hFFF);
      hs_log.delete();
      req_log.delete();
      repeat (6) tick(1'b0, 1'b1, 1'b0, '0);
      if (req_log.size() >= 2) begin
         chk("t5_req0", {52'd0, req_log[0]}, 64'hFFF);
         chk("t5_req1", {52'd0, req_log[1]}, 64'h000);
      end else timeout_fail("t5_reqs");
      if (hs_log.size() >= 2) begin
         chk("t5_pc0", {52'd0, hs_log[0].pc}, 64'hFFF);
         chk("t5_pc1", {52'd0, hs_log[1].pc}, 64'h000);
      end else timeout_fail("t5_deqs");

      // leave HALTED with a redirect
      do_reset();
      mem[0] = 32'hB123_4567;
      repeat (6) tick(1'b0, 1'b1, 1'b0, '0);
      chk("t6_halted", {63'd0, bus_if.halted}, 64'd1);
      tick(1'b0, 1'b1, 1'b1, 12'h010);
      tick(1'b0, 1'b0, 1'b0, '0);
      chk("t6_unhalted", {63'd0, bus_if.halted}, 64'd0);
      chk("t6_req", {63'd0, bus_if.mem_req}, 64'd1);
      chk("t6_addr", {52'd0, bus_if.mem_addr}, 64'h010);

      // reset while a request is outstanding; acks around it are ignored
      resp_en   = 1'b0;
      force_ack = 1'b0;
      do_reset();
      tick(1'b0, 1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, 1'b0, '0);
      chk("t7_req_up", {63'd0, bus_if.mem_req}, 64'd1);
      force_ack = 1'b1;
      tick(1'b1, 1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, 1'b0, '0);
      chk("t7_req_dropped", {63'd0, bus_if.mem_req}, 64'd0);
      force_ack = 1'b0;
      tick(1'b0, 1'b0, 1'b0, '0);
      chk("t7_req_again", {63'd0, bus_if.mem_req}, 64'd1);
      chk("t7_valid_low", {63'd0, bus_if.ir_valid}, 64'd0);
      chk("t7_not_halted", {63'd0, bus_if.halted}, 64'd0);
      tick(1'b0, 1'b0, 1'b0, '0);
      resp_en = 1'b1;

      // randomized traffic
      for (int i = 0; i < 4096; i++) mem[i] = rand_word(1'b1);
      fixed_lat = 0;
      do_reset();
      for (int i = 0; i < 1200; i++) begin
         tick(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0),
              AW'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
